// File: rtl/fir_seq_pkg.sv
// Shared defaults and helpers for the fir_core host-side sample sequencer.
package fir_seq_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  // Saturating +1 for a counter of width w (w <= 32); the caller truncates the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << w) - 64'd1);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fir_seq_fifo.sv
// Synchronous result FIFO. A push on a full FIFO is still taken when a pop
// happens in the same cycle; otherwise it is ignored, and the caller counts the drop.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push_i, push_dat_i    write request and data
//   pop_i                 read request (ignored while empty)
//   dat_o                 oldest entry, combinational read
//   full_o, empty_o       occupancy flags
module fir_seq_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dat_o   = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Host-side adapter for fir_core: turns the core's ccs x/y wires into valid/ready streams.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_vld, in_rdy, in_dat      upstream sample stream
//   x_rsc_dat, x_triosy_lz      sample to core, core "x consumed" strobe
//   y_rsc_dat, y_triosy_lz      result from core, core "y valid" strobe
//   out_vld, out_rdy, out_dat   downstream result stream (FIFO head)
//   clear                       clears both counters
//   underrun_cnt, overflow_cnt  saturating event counters
module fir_sample_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ZERO_FILL  = 0,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_dat,
  output logic [DATA_W-1:0] x_rsc_dat,
  input  logic              x_triosy_lz,
  input  logic [DATA_W-1:0] y_rsc_dat,
  input  logic              y_triosy_lz,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_dat,
  input  logic              clear,
  output logic [CNT_W-1:0]  underrun_cnt,
  output logic [CNT_W-1:0]  overflow_cnt
);

  logic              x_prev_q, y_prev_q;
  logic [DATA_W-1:0] xh_q, xh_d;
  logic [DATA_W-1:0] xp_q, xp_d;
  logic              xp_v_q, xp_v_d;
  logic [CNT_W-1:0]  und_q, und_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;
  logic              x_evt, y_evt, accept, underrun, overflow, pop;
  logic              fifo_full, fifo_empty;

  // Input staging, strobe edges and counter next-state.
  always_comb begin
    x_evt    = x_triosy_lz & ~x_prev_q;
    y_evt    = y_triosy_lz & ~y_prev_q;
    in_rdy   = ~xp_v_q & ~rst;
    accept   = in_vld & in_rdy;
    pop      = ~fifo_empty & out_rdy;
    xh_d     = xh_q;
    xp_d     = xp_q;
    xp_v_d   = xp_v_q;
    underrun = 1'b0;
    overflow = y_evt & fifo_full & ~pop;

    if (x_evt) begin
      if (xp_v_q) begin
        xh_d   = xp_q;
        xp_v_d = 1'b0;
      end else if (accept) begin
        xh_d = in_dat;  // bypass: sample arrives in the very frame it is needed
      end else begin
        underrun = 1'b1;
        if (ZERO_FILL != 0) xh_d = '0;
      end
    end else if (accept) begin
      xp_d   = in_dat;
      xp_v_d = 1'b1;
    end

    und_d = und_q;
    ovf_d = ovf_q;
    if (clear) begin
      und_d = '0;
      ovf_d = '0;
    end else begin
      if (underrun) und_d = CNT_W'(sat_inc(32'(und_q), CNT_W));
      if (overflow) ovf_d = CNT_W'(sat_inc(32'(ovf_q), CNT_W));
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_prev_q <= 1'b0;
      y_prev_q <= 1'b0;
      xh_q     <= '0;
      xp_q     <= '0;
      xp_v_q   <= 1'b0;
      und_q    <= '0;
      ovf_q    <= '0;
    end else begin
      x_prev_q <= x_triosy_lz;
      y_prev_q <= y_triosy_lz;
      xh_q     <= xh_d;
      xp_q     <= xp_d;
      xp_v_q   <= xp_v_d;
      und_q    <= und_d;
      ovf_q    <= ovf_d;
    end
  end

  fir_seq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (y_evt),
    .push_dat_i (y_rsc_dat),
    .pop_i      (out_rdy),
    .dat_o      (out_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign x_rsc_dat    = xh_q;
  assign out_vld      = ~fifo_empty;
  assign underrun_cnt = und_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: two instances (repeat-last with 16-bit counters,
// zero-fill with 8-bit counters) share one stimulus; a queue-based model is compared
// every cycle, and directed literal expectations pin the model.
module tb_fir_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic [31:0] in_dat = '0;
  logic        x_lz = 1'b0;
  logic        y_lz = 1'b0;
  logic [31:0] y_dat = '0;
  logic        out_rdy = 1'b0;
  logic        clear = 1'b0;

  logic        a_in_rdy, b_in_rdy, a_out_vld, b_out_vld;
  logic [31:0] a_x, b_x, a_out, b_out;
  logic [15:0] a_ur, a_ov;
  logic [7:0]  b_ur, b_ov;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_sample_sequencer #(.DATA_W(32), .FIFO_DEPTH(4), .ZERO_FILL(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(a_in_rdy), .in_dat(in_dat),
    .x_rsc_dat(a_x), .x_triosy_lz(x_lz), .y_rsc_dat(y_dat), .y_triosy_lz(y_lz),
    .out_vld(a_out_vld), .out_rdy(out_rdy), .out_dat(a_out), .clear(clear),
    .underrun_cnt(a_ur), .overflow_cnt(a_ov));

  fir_sample_sequencer #(.DATA_W(32), .FIFO_DEPTH(4), .ZERO_FILL(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(b_in_rdy), .in_dat(in_dat),
    .x_rsc_dat(b_x), .x_triosy_lz(x_lz), .y_rsc_dat(y_dat), .y_triosy_lz(y_lz),
    .out_vld(b_out_vld), .out_rdy(out_rdy), .out_dat(b_out), .clear(clear),
    .underrun_cnt(b_ur), .overflow_cnt(b_ov));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: one staged sample, a held frame value per fill mode,
  // a result queue and unbounded event counts saturated only when compared.
  bit          m_started = 0;
  bit          m_xprev, m_yprev, m_sv;
  logic [31:0] m_sd, m_xh, m_xhz;
  logic [31:0] m_q[$];
  int          m_ur, m_ov;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_started = 1;
      m_xprev = 0; m_yprev = 0; m_sv = 0; m_sd = '0;
      m_xh = '0; m_xhz = '0; m_ur = 0; m_ov = 0;
      m_q.delete();
    end else begin
      bit xe, ye, acc;
      xe  = x_lz && !m_xprev;
      ye  = y_lz && !m_yprev;
      acc = in_vld && !m_sv;
      if (xe) begin
        if (m_sv) begin m_xh = m_sd; m_xhz = m_sd; m_sv = 0; end
        else if (acc) begin m_xh = in_dat; m_xhz = in_dat; end
        else begin m_xhz = '0; m_ur++; end
      end else if (acc) begin
        m_sd = in_dat; m_sv = 1;
      end
      if (m_q.size() != 0 && out_rdy) void'(m_q.pop_front());
      if (ye) begin
        if (m_q.size() < 4) m_q.push_back(y_dat);
        else m_ov++;
      end
      if (clear) begin m_ur = 0; m_ov = 0; end
      m_xprev = x_lz;
      m_yprev = y_lz;
    end
  end

  function automatic logic [31:0] sat(input int v, input int mx);
    return 32'((v > mx) ? mx : v);
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_started) begin
      chk("m_x_a", a_x, m_xh);
      chk("m_x_b", b_x, m_xhz);
      chk("m_in_rdy_a", 32'(a_in_rdy), 32'(!m_sv && !rst));
      chk("m_in_rdy_b", 32'(b_in_rdy), 32'(!m_sv && !rst));
      chk("m_out_vld_a", 32'(a_out_vld), 32'(m_q.size() != 0));
      chk("m_out_vld_b", 32'(b_out_vld), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("m_out_dat_a", a_out, m_q[0]);
        chk("m_out_dat_b", b_out, m_q[0]);
      end
      chk("m_ur_a", 32'(a_ur), sat(m_ur, 16'hFFFF));
      chk("m_ov_a", 32'(a_ov), sat(m_ov, 16'hFFFF));
      chk("m_ur_b", 32'(b_ur), sat(m_ur, 8'hFF));
      chk("m_ov_b", 32'(b_ov), sat(m_ov, 8'hFF));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic feed(input logic [31:0] v);
    in_vld = 1'b1; in_dat = v; step(); in_vld = 1'b0;
  endtask

  task automatic x_pulse();
    x_lz = 1'b1; step(); x_lz = 1'b0; step();
  endtask

  task automatic y_pulse(input logic [31:0] v);
    y_dat = v; y_lz = 1'b1; step(); y_lz = 1'b0; step();
  endtask

  initial begin
    step(2);
    chk("rst_x", a_x, 32'h0);
    chk("rst_in_rdy", 32'(a_in_rdy), 32'h0);
    rst = 1'b0;
    step();
    chk("post_rst_in_rdy", 32'(a_in_rdy), 32'h1);

    // Normal flow: one sample per frame.
    feed(32'h11);
    chk("staged_in_rdy", 32'(a_in_rdy), 32'h0);
    x_pulse();
    chk("flow_x11", a_x, 32'h11);
    feed(32'h22); x_pulse();
    chk("flow_x22", a_x, 32'h22);
    feed(32'h33); x_pulse();
    chk("flow_x33", a_x, 32'h33);
    chk("flow_ur", 32'(a_ur), 32'h0);

    // Bypass then underrun in both fill modes.
    in_vld = 1'b1; in_dat = 32'hAA; x_lz = 1'b1; step();
    in_vld = 1'b0; x_lz = 1'b0;
    chk("bypass_x_a", a_x, 32'hAA);
    chk("bypass_x_b", b_x, 32'hAA);
    chk("bypass_in_rdy", 32'(a_in_rdy), 32'h1);
    step(); x_pulse();
    chk("underrun_hold_a", a_x, 32'hAA);
    chk("underrun_zero_b", b_x, 32'h0);
    chk("underrun_cnt_a", 32'(a_ur), 32'h1);
    chk("underrun_cnt_b", 32'(b_ur), 32'h1);

    // Strobes held high give one event each.
    feed(32'h55);
    x_lz = 1'b1; step(5); x_lz = 1'b0; step();
    chk("held_x", a_x, 32'h55);
    chk("held_ur", 32'(a_ur), 32'h1);
    y_dat = 32'h77; y_lz = 1'b1; step(5); y_lz = 1'b0; step();
    chk("held_y_vld", 32'(a_out_vld), 32'h1);
    chk("held_y_dat", a_out, 32'h77);
    out_rdy = 1'b1; step(); out_rdy = 1'b0;
    chk("held_y_single", 32'(a_out_vld), 32'h0);

    // Overflow with a depth-4 FIFO and a stalled consumer.
    for (int v = 1; v <= 5; v++) y_pulse(32'(v));
    chk("ovf_cnt", 32'(a_ov), 32'h1);
    chk("ovf_head", a_out, 32'h1);
    y_dat = 32'h9; y_lz = 1'b1; out_rdy = 1'b1; step();
    y_lz = 1'b0; out_rdy = 1'b0; step();
    chk("full_pop_push_ov", 32'(a_ov), 32'h1);
    begin
      logic [31:0] exp_seq [4];
      exp_seq = '{32'h2, 32'h3, 32'h4, 32'h9};
      for (int i = 0; i < 4; i++) begin
        chk("drain", a_out, exp_seq[i]);
        out_rdy = 1'b1; step(); out_rdy = 1'b0;
      end
    end
    chk("drained", 32'(a_out_vld), 32'h0);

    // Mid-traffic reset with three results queued and a staged sample.
    for (int v = 0; v < 3; v++) y_pulse(32'(16 + v));
    feed(32'h66);
    chk("pre_rst_vld", 32'(a_out_vld), 32'h1);
    rst = 1'b1; step();
    chk("rst_in_rdy_hi", 32'(a_in_rdy), 32'h0);
    step();
    chk("rst_vld", 32'(a_out_vld), 32'h0);
    chk("rst_x0", a_x, 32'h0);
    chk("rst_ur", 32'(a_ur), 32'h0);
    chk("rst_ov", 32'(a_ov), 32'h0);
    rst = 1'b0; step();
    chk("rst_in_rdy_after", 32'(a_in_rdy), 32'h1);

    // Counter saturation (8-bit instance) and clear-vs-increment priority.
    for (int i = 0; i < 260; i++) x_pulse();
    chk("sat_b", 32'(b_ur), 32'hFF);
    chk("nosat_a", 32'(a_ur), 32'd260);
    clear = 1'b1; x_lz = 1'b1; step();
    clear = 1'b0; x_lz = 1'b0;
    chk("clear_a", 32'(a_ur), 32'h0);
    chk("clear_b", 32'(b_ur), 32'h0);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
